// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stage and the multicycle divider. Pipeline writes always win.
// Divider results queue in a small ordered circular buffer and drain into idle
// write-port cycles. Decode can hold off using stall_req and pending_mask.
module wb_port_arbiter #(
  parameter int          DEPTH      = 2,
  parameter int          STATUS_REG = 30,
  parameter logic [31:0] ERR_CODE   = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [4:0]  div_reg,
  input  logic [31:0] div_data,
  input  logic        div_err,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [4:0]     STATUS_R = 5'(STATUS_REG);

  // Queue storage: valid bits are control (reset), reg/data are payload.
  logic          q_vld  [DEPTH];
  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          wb_act;
  logic          accept;
  logic [4:0]    ent_reg;
  logic [31:0]   ent_data;
  logic          ent_discard;
  logic          ent_vld;
  logic          kill_en;
  logic          empty;
  logic          head_vld;
  logic          cut;
  logic          push;
  logic          pop;
  logic          sel_we;
  logic [4:0]    sel_reg;
  logic [31:0]   sel_data;

  // Requests are ignored while reset is held low so no write leaks out.
  assign wb_act    = wb_valid & reset;
  assign div_ready = (count < DEPTH_C);
  assign accept    = div_valid & reset & div_ready;
  assign empty     = (count == '0);
  assign head_vld  = !empty && q_vld[rd_ptr];
  assign stall_req = !empty;
  assign kill_en   = wb_act && (wb_reg != 5'd0);

  // Map an accepted divider result onto the entry it would become.
  always_comb begin
    ent_reg     = div_reg;
    ent_data    = div_data;
    ent_discard = 1'b0;
    if (div_err) begin
      ent_reg  = STATUS_R;
      ent_data = ERR_CODE;
    end else if (div_reg == 5'd0) begin
      ent_discard = 1'b1;
    end
    // A same-cycle pipeline write to the same target supersedes this result.
    ent_vld = !(kill_en && (ent_reg == wb_reg));
  end

  // Write-port selection: pipeline, then queue head, then cut-through.
  always_comb begin
    sel_we   = 1'b0;
    sel_reg  = wb_reg;
    sel_data = wb_data;
    pop      = 1'b0;
    cut      = 1'b0;
    if (wb_act) begin
      sel_we = 1'b1;
      // A killed head can still retire under a pipeline write.
      pop    = !empty && !head_vld;
    end else if (head_vld) begin
      sel_we   = 1'b1;
      sel_reg  = q_reg[rd_ptr];
      sel_data = q_data[rd_ptr];
      pop      = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end else if (accept) begin
      cut      = 1'b1;
      sel_we   = 1'b1;
      sel_reg  = ent_reg;
      sel_data = ent_data;
    end
    push = accept && !cut && !ent_discard;
  end

  assign ctrl_writeEnable = sel_we && (sel_reg != 5'd0);
  assign ctrl_writeReg    = sel_reg;
  assign data_writeReg    = sel_data;

  // Destinations still owed a write by a live queued entry.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pending_mask[q_reg[i]] = 1'b1;
    end
  end

  // Queue control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q_vld[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (q_reg[i] == wb_reg)) q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      // The push slot is never the popped slot: a full queue cannot accept.
      if (push) begin
        q_vld[wr_ptr] <= ent_vld;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload: destination and data captured on push.
  always_ff @(posedge clock) begin
    if (push) begin
      q_reg[wr_ptr]  <= ent_reg;
      q_data[wr_ptr] <= ent_data;
    end
  end

endmodule
